// File: rtl/lsu_sram_if.sv
// Request/response channel between the EXU/LSU stage and the SRAM-backed load/store unit.
// Both channels use a valid/ready handshake.
interface lsu_sram_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_wen;
  logic [2:0]  req_func;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_wen, req_func, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_wen, req_func, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/lsu_sram.sv
// Multi-cycle RISC-V load/store unit backed by a word-organised on-chip SRAM.
// Takes one request at a time and responds a fixed LATENCY cycles after acceptance.
module lsu_sram #(
  parameter logic [31:0] ADDR_BASE = 32'h8000_0000,
  parameter int unsigned DEPTH     = 1024,
  parameter int unsigned LATENCY   = 2
) (
  input logic        clk,
  input logic        rst,
  lsu_sram_if.slave  bus
);
  localparam int unsigned IW = $clog2(DEPTH);

  typedef enum logic [1:0] {StIdle, StWait, StResp} state_e;

  state_e      state_q, state_d;
  logic [3:0]  cnt_q;
  logic        wen_q;
  logic [2:0]  func_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [31:0] rsp_rdata_q;
  logic        rsp_err_q;

  logic        accept;
  logic        commit;
  logic        func_ok;
  logic        misaligned;
  logic        out_of_range;
  logic        err;
  logic [32:0] off;
  logic [IW-1:0] idx;
  logic [1:0]  lane;
  logic [3:0]  base_mask;
  logic [3:0]  be;
  logic [31:0] wdata_sh;
  logic [31:0] rd_word;
  logic [31:0] load_data;

  logic [31:0] mem [DEPTH];

  always_comb begin
    state_d = state_q;
    accept  = 1'b0;
    commit  = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (bus.req_valid) begin
          accept  = 1'b1;
          state_d = StWait;
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) begin
          commit  = 1'b1;
          state_d = StResp;
        end
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Request checks and lane steering, all evaluated on the latched request.
  always_comb begin
    off  = {1'b0, addr_q} - {1'b0, ADDR_BASE};
    idx  = off[IW+1:2];
    lane = addr_q[1:0];
    if (wen_q) begin
      func_ok = func_q inside {3'b000, 3'b001, 3'b010};
    end else begin
      func_ok = func_q inside {3'b000, 3'b001, 3'b010, 3'b100, 3'b101};
    end
    misaligned   = ((func_q[1:0] == 2'b01) && addr_q[0]) ||
                   ((func_q[1:0] == 2'b10) && (addr_q[1:0] != 2'b00));
    // A borrow into bit 32 means the address lies below the base.
    out_of_range = off[32] || (off >= (33'(DEPTH) << 2));
    err          = !func_ok || misaligned || out_of_range;

    unique case (func_q[1:0])
      2'b00:   base_mask = 4'b0001;
      2'b01:   base_mask = 4'b0011;
      default: base_mask = 4'b1111;
    endcase
    be       = base_mask << lane;
    wdata_sh = wdata_q << {lane, 3'b000};
    rd_word  = mem[idx] >> {lane, 3'b000};

    unique case (func_q)
      3'b000:  load_data = {{24{rd_word[7]}}, rd_word[7:0]};
      3'b001:  load_data = {{16{rd_word[15]}}, rd_word[15:0]};
      3'b100:  load_data = {24'h0, rd_word[7:0]};
      3'b101:  load_data = {16'h0, rd_word[15:0]};
      default: load_data = rd_word;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      cnt_q       <= 4'd0;
      rsp_rdata_q <= 32'h0;
      rsp_err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        cnt_q <= 4'(LATENCY - 1);
      end else if ((state_q == StWait) && (cnt_q != 4'd0)) begin
        cnt_q <= cnt_q - 4'd1;
      end
      if (commit) begin
        rsp_err_q   <= err;
        rsp_rdata_q <= (err || wen_q) ? 32'h0 : load_data;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (accept) begin
      wen_q   <= bus.req_wen;
      func_q  <= bus.req_func;
      addr_q  <= bus.req_addr;
      wdata_q <= bus.req_wdata;
    end
  end

  // SRAM is not reset; a reset on the commit edge suppresses the write.
  always_ff @(posedge clk) begin
    if (!rst && commit && wen_q && !err) begin
      for (int b = 0; b < 4; b++) begin
        if (be[b]) mem[idx][8*b +: 8] <= wdata_sh[8*b +: 8];
      end
    end
  end

  assign bus.req_ready = (state_q == StIdle);
  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rsp_rdata_q;
  assign bus.rsp_err   = rsp_err_q;
endmodule
